// File: rtl/vector_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vector_fifo
// Description : Single-clock FIFO with registered read data and
//               overflow/underflow pulses.
// Revision    : 1.0
// ============================================================================
module vector_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [c_CW-1:0]  w_count_nxt;

    // Acceptance uses the registered flags, so a full FIFO drops a write even
    // when a read frees a slot on the same edge (and symmetrically for empty).
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is intentionally left out of reset; empty keeps stale data hidden.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_DEPTH);
            r_empty     <= (w_count_nxt == '0);
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/vector_fifo.md
VECTOR_FIFO -- requirements
Module: vector_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-006 The block SHALL have port wr_data, input, WIDTH bits: write data.
REQ-007 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-008 The block SHALL have port rd_data, output, WIDTH bits: registered read data.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: rd_data holds newly popped data this cycle.
REQ-010 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-011 The block SHALL have port empty, output, 1 bit: count equals 0.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-013 The block SHALL have port overflow, output, 1 bit: one-cycle pulse on a rejected write.
REQ-014 The block SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected read.

Function
REQ-015 Storage SHALL be an unpacked array of DEPTH vector registers, each WIDTH bits, indexed [0:DEPTH-1].
REQ-016 A write SHALL be accepted when wr_en=1 and full=0: wr_data is stored at wr_ptr, and wr_ptr increments.
REQ-017 A read SHALL be accepted when rd_en=1 and empty=0: the entry at rd_ptr is registered into rd_data on the same edge, rd_valid=1 on the following cycle, and rd_ptr increments.
REQ-018 Read latency SHALL be 1 cycle from an accepted rd_en to rd_valid=1 with the correct rd_data.
REQ-019 When no read is accepted, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-020 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-021 When a read and a write are both accepted in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When full=1, a write SHALL be rejected even if a read is accepted in the same cycle; the read proceeds and count decrements.
REQ-023 When empty=1, a read SHALL be rejected even if a write is accepted in the same cycle; the write proceeds and count increments, with no read-through.
REQ-024 wr_en=1 with full=1 SHALL cause overflow=1 for exactly the next cycle, and storage, wr_ptr and count SHALL be unchanged by the write.
REQ-025 rd_en=1 with empty=1 SHALL cause underflow=1 for exactly the next cycle, and rd_ptr, rd_data and count SHALL be unchanged.
REQ-026 full and empty SHALL be registered, consistent with count at every edge, and never both 1.
REQ-027 count SHALL range over 0..DEPTH only; increment-only, decrement-only and hold are the only transitions.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0 and underflow=0.
REQ-029 Storage array contents SHALL NOT be reset; stale entries SHALL never be readable, because empty gates reads.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first accepted write after release is the first data read.

Verification
REQ-031 Scenario (fill and overflow): after reset, write 0x01..0x08 on consecutive cycles -> full=1 and count=8; a 9th write of 0xFF -> overflow pulses once and count stays 8.
REQ-032 Scenario (drain and underflow): read 8 times -> rd_data=0x01..0x08 in order, each 1 cycle after its rd_en, then empty=1; a 9th read -> underflow pulses and rd_data stays 0x08.
REQ-033 Scenario (wrap): write 5, read 5, then write 0xA0..0xA7 -> pointers wrap and reads return 0xA0..0xA7 in order.
REQ-034 Scenario (simultaneous): with count=3, assert wr_en and rd_en together for 4 cycles -> count stays 3 and data order is preserved.
REQ-035 Scenario (full/empty boundary): at full, assert rd_en and wr_en together -> count becomes 7 and the write is dropped with an overflow pulse; at empty, assert both -> count becomes 1, underflow pulses and rd_valid=0.
REQ-036 Scenario (async reset): with count=4, assert rst_n low between clock edges -> outputs reach reset values before the next edge; after release, write 0x55 and read -> rd_data=0x55.
